// File: rtl/line_printer_dma.sv
// ---------------------------------------------------------------------------
// line_printer_dma
//
// Output-side IOP device. On a start-I/O pulse it fetches a print buffer from
// main memory through the memory arbiter, unpacks each 32-bit word into bytes
// MSB-first and streams them to a printer sink over a valid/ready handshake.
// When the last byte has been accepted it writes a status word back to memory
// and pulses an interrupt.
//
// Ports
//   clock          system clock, all state changes on the rising edge
//   reset          synchronous, active-high
//   running        arbiter request (FETCH and STATUS only)
//   active         arbiter grant: read data valid / write accepted this cycle
//   memory_data_in combinational read data from memory
//   address        word address to the arbiter
//   data_out       status word write data
//   wr_en          byte write enables, all ones only in STATUS while granted
//   sio            start I/O pulse; sio_addr / sio_count sampled with it
//   sio_addr       buffer start word address
//   sio_count      buffer length in bytes (clamped to MAX_BYTES)
//   tio            test I/O pulse; cc shows busy/idle in the same cycle
//   cc             condition code: 0000 idle, 0100 busy, 1000 sio rejected
//   char_data      byte to the printer
//   char_valid     char_data is valid
//   char_ready     printer accepts the byte at the clock edge
//   irq            one-cycle pulse after the status write commits
// ---------------------------------------------------------------------------
module line_printer_dma #(
    parameter logic [16:0] STATUS_ADDR = 17'h0020,
    parameter logic [7:0]  MAX_BYTES   = 8'd132
) (
    input  logic        clock,
    input  logic        reset,
    output logic        running,
    input  logic        active,
    input  logic [31:0] memory_data_in,
    output logic [16:0] address,
    output logic [31:0] data_out,
    output logic [3:0]  wr_en,
    input  logic        sio,
    input  logic [16:0] sio_addr,
    input  logic [7:0]  sio_count,
    input  logic        tio,
    output logic [3:0]  cc,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        STATUS
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [16:0] ptr;
    logic [7:0]  remaining;
    logic [7:0]  sent;
    logic [1:0]  idx;
    logic [31:0] word;
    logic [3:0]  cc_reg;
    logic        irq_reg;
    logic [7:0]  count_clamped;

    // A single print line never exceeds MAX_BYTES, so longer requests are cut.
    assign count_clamped = (sio_count > MAX_BYTES) ? MAX_BYTES : sio_count;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore-style outputs. The byte presented to the printer is
    // taken from the held word register, so it cannot move while stalled.
    always_comb begin
        state_next = state;
        running    = 1'b0;
        address    = 17'h0;
        data_out   = 32'h0;
        wr_en      = 4'b0000;
        char_valid = 1'b0;
        char_data  = 8'h00;
        case (state)
            IDLE: begin
                if (sio) begin
                    state_next = (count_clamped == 8'd0) ? STATUS : FETCH;
                end
            end
            FETCH: begin
                running = 1'b1;
                address = ptr;
                if (active) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                char_valid = 1'b1;
                case (idx)
                    2'd0:    char_data = word[31:24];
                    2'd1:    char_data = word[23:16];
                    2'd2:    char_data = word[15:8];
                    default: char_data = word[7:0];
                endcase
                if (char_ready) begin
                    if (remaining == 8'd1) begin
                        state_next = STATUS;
                    end else if (idx == 2'd3) begin
                        state_next = FETCH;
                    end
                end
            end
            STATUS: begin
                running  = 1'b1;
                address  = STATUS_ADDR;
                data_out = {8'h80, 8'h00, 8'h00, sent};
                if (active) begin
                    wr_en      = 4'b1111;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transfer datapath: buffer pointer, byte bookkeeping and the word being
    // unpacked. A second sio while busy is deliberately not latched here.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= 17'h0;
            remaining <= 8'd0;
            sent      <= 8'd0;
            idx       <= 2'd0;
            word      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (sio) begin
                        ptr       <= sio_addr;
                        remaining <= count_clamped;
                        sent      <= 8'd0;
                        idx       <= 2'd0;
                    end
                end
                FETCH: begin
                    if (active) begin
                        word <= memory_data_in;
                        ptr  <= ptr + 17'd1;
                    end
                end
                EMIT: begin
                    if (char_ready) begin
                        remaining <= remaining - 8'd1;
                        sent      <= sent + 8'd1;
                        idx       <= idx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Condition code register: a rejected sio is remembered until the next
    // sio or tio; a tio records the busy/idle code it reported.
    always_ff @(posedge clock) begin
        if (reset) begin
            cc_reg <= 4'b0000;
        end else if (sio) begin
            cc_reg <= (state == IDLE) ? 4'b0000 : 4'b1000;
        end else if (tio) begin
            cc_reg <= (state == IDLE) ? 4'b0000 : 4'b0100;
        end
    end

    // The interrupt follows the cycle in which the status write was granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (state == STATUS) && active;
        end
    end

    // tio answers in the same cycle; sio takes priority when both arrive.
    always_comb begin
        cc = cc_reg;
        if (tio && !sio) begin
            cc = (state == IDLE) ? 4'b0000 : 4'b0100;
        end
    end

    assign irq = irq_reg;

endmodule
